gearbox_des: RTL and testbench

Parametrised width-converting deserializer: the next generation of the fixed 13-to-40 converter, generalised to any input width DIN_W and output width DOUT_W (DIN_W ≤ DOUT_W, ratio need not be integral). It packs a qualified stream of DIN_W-bit input words into DOUT_W-bit output words, carries leftover bits across word boundaries, supports both bit orders, and can flush a partial word. It sits between a narrow source and a wide storage/write port, where WE is used as the write strobe.

---
 rtl/gearbox_des.sv | 97 +++++++++
 tb/tb_gearbox_des.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gearbox_des.sv
`default_nettype none
// ============================================================================
// Module   : gearbox_des
// Purpose  : Packs DIN_W-bit input words into DOUT_W-bit output words.
//            Leftover bits carry over to the next word, either bit order is
//            supported, and a partial word can be flushed out zero-padded.
// Revision : 1.0  initial release
// ============================================================================
module gearbox_des #(
    parameter int  DIN_W     = 13,
    parameter int  DOUT_W    = 40,
    parameter int  MSB_FIRST = 1,
    localparam int FILL_W    = (DOUT_W > 1) ? $clog2(DOUT_W) : 1
) (
    input  logic              Cin,
    input  logic              Rst,
    input  logic              Vin,
    input  logic [DIN_W-1:0]  Din,
    input  logic              Flush,
    output logic [DOUT_W-1:0] Dout,
    output logic              WE,
    output logic [FILL_W-1:0] Fill
);

    localparam int c_ACC_W = DOUT_W + DIN_W - 1;
    localparam int c_CNT_W = $clog2(c_ACC_W + 1);

    // r_acc[j] holds the j-th buffered bit in arrival order; bits at and
    // above r_fill are always zero, so a flush can emit r_acc directly.
    logic [c_ACC_W-1:0] r_acc;
    logic [FILL_W-1:0]  r_fill;

    logic [DIN_W-1:0]   w_din_arr;
    logic [c_ACC_W-1:0] w_din_ext;
    logic [c_ACC_W-1:0] w_cat;
    logic [c_ACC_W-1:0] w_rest;
    logic [c_CNT_W-1:0] w_total;
    logic               w_emit;
    logic [DOUT_W-1:0]  w_word_arr;
    logic [DOUT_W-1:0]  w_dout;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            for (genvar i = 0; i < DIN_W; i++) begin : g_din_order
                assign w_din_arr[i] = Din[DIN_W-1-i];
            end
            for (genvar i = 0; i < DOUT_W; i++) begin : g_dout_order
                assign w_dout[DOUT_W-1-i] = w_word_arr[i];
            end
        end else begin : g_lsb_first
            assign w_din_arr = Din;
            assign w_dout    = w_word_arr;
        end
    endgenerate

    always_comb begin
        w_din_ext = '0;
        w_din_ext[DIN_W-1:0] = w_din_arr;
    end

    assign w_cat      = r_acc | (w_din_ext << r_fill);
    assign w_rest     = w_cat >> DOUT_W;
    assign w_total    = c_CNT_W'(r_fill) + c_CNT_W'(DIN_W);
    assign w_emit     = (w_total >= c_CNT_W'(DOUT_W));
    assign w_word_arr = Vin ? w_cat[DOUT_W-1:0] : r_acc[DOUT_W-1:0];

    always_ff @(posedge Cin) begin
        if (Rst) begin
            r_acc  <= '0;
            r_fill <= '0;
            Dout   <= '0;
            WE     <= 1'b0;
        end else begin
            WE <= 1'b0;
            if (Vin) begin
                if (w_emit) begin
                    Dout   <= w_dout;
                    WE     <= 1'b1;
                    r_acc  <= w_rest;
                    r_fill <= FILL_W'(w_total - c_CNT_W'(DOUT_W));
                end else begin
                    r_acc  <= w_cat;
                    r_fill <= FILL_W'(w_total);
                end
            end else if (Flush && (r_fill != '0)) begin
                Dout   <= w_dout;
                WE     <= 1'b1;
                r_acc  <= '0;
                r_fill <= '0;
            end
        end
    end

    assign Fill = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_gearbox_des.sv
`default_nettype none
// ============================================================================
// Module   : tb_gearbox_des
// Purpose  : Scoreboard bench for gearbox_des, both bit orders side by side.
// Revision : 1.0  initial release
// ============================================================================
module tb_gearbox_des;

    localparam int DIN_W  = 13;
    localparam int DOUT_W = 40;
    localparam int FILL_W = 6;

    logic              Cin = 1'b0;
    logic              rst = 1'b1;
    logic              vin = 1'b0;
    logic [DIN_W-1:0]  din = '0;
    logic              flush = 1'b0;

    logic [DOUT_W-1:0] dout_m, dout_l;
    logic              we_m, we_l;
    logic [FILL_W-1:0] fill_m, fill_l;

    int checks = 0;
    int errors = 0;

    always #5 Cin = ~Cin;

    gearbox_des #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .MSB_FIRST(1)) dut_m (
        .Cin(Cin), .Rst(rst), .Vin(vin), .Din(din), .Flush(flush),
        .Dout(dout_m), .WE(we_m), .Fill(fill_m)
    );

    gearbox_des #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .MSB_FIRST(0)) dut_l (
        .Cin(Cin), .Rst(rst), .Vin(vin), .Din(din), .Flush(flush),
        .Dout(dout_l), .WE(we_l), .Fill(fill_l)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-order queues of bits in arrival order.
    bit                bq_m[$], bq_l[$];
    logic [DOUT_W-1:0] eq_m[$], eq_l[$];
    logic [DOUT_W-1:0] hold_m = '0, hold_l = '0;
    bit                seen = 0;

    task automatic take_m(input int n, output logic [DOUT_W-1:0] w);
        w = '0;
        for (int i = 0; i < n; i++) w[DOUT_W-1-i] = bq_m.pop_front();
    endtask

    task automatic take_l(input int n, output logic [DOUT_W-1:0] w);
        w = '0;
        for (int i = 0; i < n; i++) w[i] = bq_l.pop_front();
    endtask

    always @(posedge Cin) begin
        logic [DOUT_W-1:0] w;
        int n;
        seen = 1;
        if (rst) begin
            bq_m.delete(); bq_l.delete(); eq_m.delete(); eq_l.delete();
            hold_m = '0; hold_l = '0;
        end else if (vin) begin
            for (int i = 0; i < DIN_W; i++) begin
                bq_m.push_back(din[DIN_W-1-i]);
                bq_l.push_back(din[i]);
            end
            if (bq_m.size() >= DOUT_W) begin
                take_m(DOUT_W, w); hold_m = w; eq_m.push_back(w);
                take_l(DOUT_W, w); hold_l = w; eq_l.push_back(w);
            end
        end else if (flush && bq_m.size() > 0) begin
            n = bq_m.size();
            take_m(n, w); hold_m = w; eq_m.push_back(w);
            take_l(n, w); hold_l = w; eq_l.push_back(w);
        end
    end

    // Monitor: any strobe must match a queued word; otherwise Dout holds.
    always @(negedge Cin) begin
        logic [DOUT_W-1:0] e;
        if (seen) begin
            if (eq_m.size() > 0) begin
                e = eq_m.pop_front();
                chk("we_m", 64'(we_m), 64'd1);
                chk("dout_m", 64'(dout_m), 64'(e));
            end else begin
                chk("we_m_idle", 64'(we_m), 64'd0);
                chk("dout_m_hold", 64'(dout_m), 64'(hold_m));
            end
            if (eq_l.size() > 0) begin
                e = eq_l.pop_front();
                chk("we_l", 64'(we_l), 64'd1);
                chk("dout_l", 64'(dout_l), 64'(e));
            end else begin
                chk("we_l_idle", 64'(we_l), 64'd0);
                chk("dout_l_hold", 64'(dout_l), 64'(hold_l));
            end
            chk("fill_m", 64'(fill_m), 64'(bq_m.size()));
            chk("fill_l", 64'(fill_l), 64'(bq_l.size()));
        end
    end

    task automatic step(input logic v, input logic [DIN_W-1:0] d, input logic f, input logic r);
        vin = v; din = d; flush = f; rst = r;
        @(posedge Cin);
        #1;
    endtask

    localparam logic [DIN_W-1:0] c_PAT = 13'b1100110011001;

    initial begin
        int gap;
        logic [DIN_W-1:0] lsb_words [4];
        lsb_words[0] = 13'h0001; lsb_words[1] = 13'h0002;
        lsb_words[2] = 13'h0003; lsb_words[3] = 13'h1FFF;

        // Reset with active input
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 13'h1FFF, 1'b0, 1'b1);
            chk("rst_we", 64'(we_m), 64'd0);
            chk("rst_dout", 64'(dout_m), 64'd0);
            chk("rst_fill", 64'(fill_m), 64'd0);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        chk("post_rst_fill", 64'(fill_l), 64'd0);

        // Four back-to-back words, MSB first
        for (int i = 0; i < 4; i++) step(1'b1, c_PAT, 1'b0, 1'b0);
        chk("s2_we", 64'(we_m), 64'd1);
        chk("s2_dout", 64'(dout_m), 64'hCC_CE66_7333);
        chk("s2_fill", 64'(fill_m), 64'd12);

        step(1'b0, '0, 1'b1, 1'b0);
        chk("flush_we", 64'(we_m), 64'd1);
        chk("flush_dout", 64'(dout_m), 64'h99_9000_0000);
        chk("flush_fill", 64'(fill_m), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("flush2_we", 64'(we_m), 64'd0);
        chk("flush2_dout", 64'(dout_m), 64'h99_9000_0000);

        // LSB-first placement
        for (int i = 0; i < 4; i++) step(1'b1, lsb_words[i], 1'b0, 1'b0);
        chk("lsb_we", 64'(we_l), 64'd1);
        chk("lsb_dout", 64'(dout_l), 64'h80_0C00_4001);
        chk("lsb_fill", 64'(fill_l), 64'd12);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("lsb_flush_dout", 64'(dout_l), 64'h00_0000_0FFF);

        // Gapped input, flush asserted together with a valid word
        for (int i = 0; i < 4; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step(1'b0, '0, 1'b0, 1'b0);
            step(1'b1, c_PAT, (i == 1), 1'b0);
        end
        chk("gap_dout", 64'(dout_m), 64'hCC_CE66_7333);
        chk("gap_fill", 64'(fill_m), 64'd12);
        step(1'b0, '0, 1'b1, 1'b0);

        // Reset in the middle of a word
        for (int i = 0; i < 2; i++) step(1'b1, c_PAT, 1'b0, 1'b0);
        chk("mid_fill", 64'(fill_m), 64'd26);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("mid_rst_fill", 64'(fill_m), 64'd0);
        for (int i = 0; i < 4; i++) step(1'b1, c_PAT, 1'b0, 1'b0);
        chk("mid_dout", 64'(dout_m), 64'hCC_CE66_7333);
        chk("mid_after_fill", 64'(fill_m), 64'd12);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), DIN_W'($urandom),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0));
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
